// File: rtl/serial_negator.sv
// Bit-serial two's-complement sign unit: pass, negate, abs, ones' complement.
// One bit per clock, LSB first, with a single registered carry.
// The operand is inverted (or not) and then incremented by the seeded carry.
module serial_negator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             inv_q, inv_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic accept;
  logic last_bit;
  logic bit_x;

  assign accept   = in_valid & in_ready;
  assign last_bit = (cnt_q == LastCnt);
  // The operand register shifts right, so the current bit is always at position 0.
  assign bit_x    = op_q[0] ^ inv_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBusy;
      StBusy: if (last_bit) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; results are only visible in DONE
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StBusy);
    out_valid = (state_q == StDone);
    out_data  = (state_q == StDone) ? res_q : '0;
    out_ovf   = (state_q == StDone) ? ovf_q : 1'b0;
  end

  // Datapath next-state: seed inv/carry on accept, then one serial bit per cycle
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    inv_d   = inv_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    res_d   = res_q;
    if (state_q == StIdle && accept) begin
      op_d  = in_data;
      cnt_d = '0;
      unique case (in_mode)
        2'b00: begin inv_d = 1'b0;             carry_d = 1'b0;             end
        2'b01: begin inv_d = 1'b1;             carry_d = 1'b1;             end
        2'b10: begin inv_d = in_data[WIDTH-1]; carry_d = in_data[WIDTH-1]; end
        default: begin inv_d = 1'b1;           carry_d = 1'b0;             end
      endcase
      // Negating the most-negative value wraps back onto itself.
      ovf_d = (in_mode == 2'b01 || in_mode == 2'b10) && (in_data == MinNeg);
    end else if (state_q == StBusy) begin
      res_d   = {bit_x ^ carry_q, res_q[WIDTH-1:1]};
      carry_d = bit_x & carry_q;
      op_d    = op_q >> 1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_serial_negator.sv
// Bench for serial_negator: a WIDTH=8 and a WIDTH=16 instance, an arithmetic
// reference model checked every cycle, and directed literal expectations.
module tb_serial_negator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-unit stimulus (index 0: WIDTH=8, index 1: WIDTH=16)
  logic        iv [2];
  logic [63:0] id [2];
  logic [1:0]  im [2];
  logic        orr[2];
  // Per-unit observed outputs, widened to 64 bits
  logic        ir [2];
  logic        ov [2];
  logic        of [2];
  logic        bz [2];
  logic [63:0] od [2];
  logic [7:0]  od8;
  logic [15:0] od16;
  assign od[0] = {56'd0, od8};
  assign od[1] = {48'd0, od16};

  serial_negator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][7:0]),
    .in_mode(im[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od8),
    .out_ovf(of[0]), .busy(bz[0])
  );

  serial_negator #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1][15:0]),
    .in_mode(im[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od16),
    .out_ovf(of[1]), .busy(bz[1])
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, result} from plain modular arithmetic.
  function automatic logic [64:0] model(int w, logic [1:0] m, logic [63:0] d);
    logic [63:0] mask, dm, minv, r;
    logic        o;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    dm   = d & mask;
    minv = 64'd1 << (w - 1);
    case (m)
      2'b00:   r = dm;
      2'b01:   r = (64'd0 - dm) & mask;
      2'b10:   r = ((dm & minv) != 0) ? ((64'd0 - dm) & mask) : dm;
      default: r = ~dm & mask;
    endcase
    o = (m == 2'b01 || m == 2'b10) && (dm == minv);
    return {o, r};
  endfunction

  // Monitor state per unit
  bit          inflight[2] = '{0, 0};
  int          lat     [2] = '{0, 0};
  logic [63:0] exp_d   [2];
  logic        exp_o   [2];
  int          acc_n   [2] = '{0, 0};
  int          acc_cyc [2] = '{0, 0};
  int          acc_prev[2] = '{0, 0};

  task automatic mon(int u, int w);
    logic [64:0] e;
    if (!rst_n) begin
      inflight[u] = 0;
      chk("rst_valid", 64'(ov[u]), 0);
      chk("rst_data", od[u], 0);
      chk("rst_ovf", 64'(of[u]), 0);
      chk("rst_busy", 64'(bz[u]), 0);
      return;
    end
    if (inflight[u]) begin
      lat[u]++;
      chk("busy", 64'(bz[u]), 64'(lat[u] >= 1 && lat[u] <= w));
      chk("valid", 64'(ov[u]), 64'(lat[u] > w));
      chk("in_ready_held", 64'(ir[u]), 0);
      if (lat[u] > w) begin
        chk("model_data", od[u], exp_d[u]);
        chk("model_ovf", 64'(of[u]), 64'(exp_o[u]));
        if (ov[u] && orr[u]) inflight[u] = 0;
      end else begin
        chk("midshift_data", od[u], 0);
        chk("midshift_ovf", 64'(of[u]), 0);
      end
    end else begin
      chk("idle_valid", 64'(ov[u]), 0);
      chk("idle_busy", 64'(bz[u]), 0);
      chk("idle_ready", 64'(ir[u]), 1);
      chk("idle_data", od[u], 0);
      if (iv[u] && ir[u]) begin
        e = model(w, im[u], id[u]);
        exp_o[u]    = e[64];
        exp_d[u]    = e[63:0];
        inflight[u] = 1;
        lat[u]      = 0;
        acc_n[u]++;
        acc_prev[u] = acc_cyc[u];
        acc_cyc[u]  = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 8);
    mon(1, 16);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One operation with optional backpressure and literal expected result.
  task automatic do_op(int u, int w, logic [1:0] m, logic [63:0] d, int hold,
                       logic [63:0] ed, logic eo);
    int n;
    n = 0;
    while (!ir[u] && n < 50) begin step(); n++; end
    chk("op_ready_wait", 64'(ir[u]), 1);
    iv[u] = 1'b1; id[u] = d; im[u] = m;
    step();
    iv[u] = 1'b0; id[u] = ~d; im[u] = ~m;  // must not disturb the latched operation
    n = 0;
    while (!ov[u] && n < 100) begin step(); n++; end
    chk("op_latency", 64'(n), 64'(w));
    for (int i = 0; i < hold; i++) begin
      iv[u] = 1'b1;
      step();
      chk("bp_in_ready", 64'(ir[u]), 0);
      chk("bp_valid", 64'(ov[u]), 1);
      chk("bp_data", od[u], ed);
    end
    iv[u] = 1'b0;
    chk("lit_data", od[u], ed);
    chk("lit_ovf", 64'(of[u]), 64'(eo));
    orr[u] = 1'b1;
    step();
    orr[u] = 1'b0;
    chk("post_ready", 64'(ir[u]), 1);
    chk("post_valid", 64'(ov[u]), 0);
  endtask

  logic [63:0] b2b_res[$];

  initial begin
    int n;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; id[u] = '0; im[u] = 2'b00; orr[u] = 1'b0;
    end
    repeat (3) step();
    chk("reset_valid", 64'(ov[0]), 0);
    chk("reset_data", od[0], 0);
    rst_n = 1'b1;
    step();
    chk("release_ready8", 64'(ir[0]), 1);
    chk("release_ready16", 64'(ir[1]), 1);

    do_op(0, 8, 2'b01, 64'h05, 0, 64'hFB, 1'b0);
    do_op(0, 8, 2'b01, 64'h80, 0, 64'h80, 1'b1);
    do_op(0, 8, 2'b10, 64'h80, 0, 64'h80, 1'b1);
    do_op(0, 8, 2'b01, 64'h00, 0, 64'h00, 1'b0);
    do_op(0, 8, 2'b10, 64'hF6, 0, 64'h0A, 1'b0);
    do_op(0, 8, 2'b10, 64'h0A, 0, 64'h0A, 1'b0);
    do_op(0, 8, 2'b11, 64'h5A, 5, 64'hA5, 1'b0);
    do_op(0, 8, 2'b00, 64'h3C, 0, 64'h3C, 1'b0);

    // Reset while bit 3 is being shifted
    iv[0] = 1'b1; id[0] = 64'h05; im[0] = 2'b01;
    step();
    iv[0] = 1'b0;
    repeat (3) step();
    chk("pre_rst_busy", 64'(bz[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ov[0]), 0);
    chk("async_rst_data", od[0], 0);
    chk("async_rst_ovf", 64'(of[0]), 0);
    chk("async_rst_busy", 64'(bz[0]), 0);
    step();
    rst_n = 1'b1;
    chk("after_rst_ready", 64'(ir[0]), 1);
    do_op(0, 8, 2'b01, 64'h01, 0, 64'hFF, 1'b0);

    // WIDTH=16 back-to-back with the consumer always ready
    orr[1] = 1'b1;
    iv[1] = 1'b1; id[1] = 64'h0001; im[1] = 2'b01;
    n = 0;
    while ((acc_n[1] < 2 || b2b_res.size() < 2) && n < 100) begin
      step();
      n++;
      if (acc_n[1] >= 1) id[1] = 64'h7FFF;
      if (acc_n[1] >= 2) iv[1] = 1'b0;
      if (ov[1]) b2b_res.push_back(od[1]);
    end
    iv[1] = 1'b0;
    chk("b2b_count", 64'(b2b_res.size()), 2);
    if (b2b_res.size() >= 2) begin
      chk("b2b_first", b2b_res[0], 64'hFFFF);
      chk("b2b_second", b2b_res[1], 64'h8001);
    end
    chk("b2b_spacing", 64'(acc_cyc[1] - acc_prev[1]), 18);
    orr[1] = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
